// File: rtl/decode_queue_if.sv
// Fetch, register-file, ROB and dispatch signals of decode_queue.
// The slave modport is the queue's view and the master modport is the surrounding pipeline's view.
interface decode_queue_if #(
  parameter int unsigned ROB_IDX_W = 4
);
  logic                 rdy_in;
  logic                 rob_clear;
  logic                 if_valid;
  logic [31:0]          if_addr;
  logic [31:0]          if_data;
  logic                 if_ready;
  logic                 f_redirect;
  logic [31:0]          f_redirect_pc;
  logic [4:0]           rf_idx1, rf_idx2;
  logic [31:0]          rf_val1, rf_val2;
  logic                 rf_has_dep1, rf_has_dep2;
  logic [ROB_IDX_W-1:0] rf_dep1, rf_dep2;
  logic [ROB_IDX_W-1:0] rob_q_idx1, rob_q_idx2;
  logic                 rob_q_rdy1, rob_q_rdy2;
  logic [31:0]          rob_q_val1, rob_q_val2;
  logic [ROB_IDX_W-1:0] rob_tail;
  logic                 rob_full, rs_full, lsb_full;
  logic                 d_valid;
  logic [1:0]           d_unit;
  logic [4:0]           d_op;
  logic [31:0]          d_r1, d_r2;
  logic                 d_has_dep1, d_has_dep2;
  logic [ROB_IDX_W-1:0] d_dep1, d_dep2;
  logic [31:0]          d_imm;
  logic [4:0]           d_rd;
  logic                 d_rob_ready;
  logic [31:0]          d_rob_value;
  logic                 d_pred_taken;
  logic [31:0]          d_addr;

  modport slave (
    input  rdy_in, rob_clear, if_valid, if_addr, if_data,
    input  rf_val1, rf_val2, rf_has_dep1, rf_has_dep2, rf_dep1, rf_dep2,
    input  rob_q_rdy1, rob_q_rdy2, rob_q_val1, rob_q_val2, rob_tail,
    input  rob_full, rs_full, lsb_full,
    output if_ready, f_redirect, f_redirect_pc, rf_idx1, rf_idx2, rob_q_idx1, rob_q_idx2,
    output d_valid, d_unit, d_op, d_r1, d_r2, d_has_dep1, d_has_dep2, d_dep1, d_dep2,
    output d_imm, d_rd, d_rob_ready, d_rob_value, d_pred_taken, d_addr
  );

  modport master (
    output rdy_in, rob_clear, if_valid, if_addr, if_data,
    output rf_val1, rf_val2, rf_has_dep1, rf_has_dep2, rf_dep1, rf_dep2,
    output rob_q_rdy1, rob_q_rdy2, rob_q_val1, rob_q_val2, rob_tail,
    output rob_full, rs_full, lsb_full,
    input  if_ready, f_redirect, f_redirect_pc, rf_idx1, rf_idx2, rob_q_idx1, rob_q_idx2,
    input  d_valid, d_unit, d_op, d_r1, d_r2, d_has_dep1, d_has_dep2, d_dep1, d_dep2,
    input  d_imm, d_rd, d_rob_ready, d_rob_value, d_pred_taken, d_addr
  );
endinterface

// File: rtl/decode_queue.sv
// Instruction queue plus RV32I decoder: buffers fetched words, renames operands and dispatches
// one registered packet per cycle, with static backward-taken branch prediction.
module decode_queue #(
  parameter int unsigned IQ_DEPTH_BIT = 2,
  parameter int unsigned ROB_IDX_W    = 4,
  parameter bit          PRED_EN      = 1'b1
) (
  input logic            clk_in,
  input logic            rst_in,
  decode_queue_if.slave  bus
);
  localparam int unsigned Depth = 1 << IQ_DEPTH_BIT;

  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpReg    = 7'b0110011;

  typedef struct packed {
    logic                 valid;
    logic [1:0]           unit;
    logic [4:0]           op;
    logic [31:0]          r1;
    logic [31:0]          r2;
    logic                 has_dep1;
    logic                 has_dep2;
    logic [ROB_IDX_W-1:0] dep1;
    logic [ROB_IDX_W-1:0] dep2;
    logic [31:0]          imm;
    logic [4:0]           rd;
    logic                 rob_ready;
    logic [31:0]          rob_value;
    logic                 pred_taken;
    logic [31:0]          addr;
  } pkt_t;

  typedef struct packed {
    logic                 dep;
    logic [ROB_IDX_W-1:0] idx;
    logic [31:0]          val;
  } opnd_t;

  logic [IQ_DEPTH_BIT:0]   head_q, tail_q;
  logic [31:0]             addr_mem [Depth];
  logic [31:0]             data_mem [Depth];
  pkt_t                    pkt_q, pkt_n;
  logic                    f_redirect_q;
  logic [31:0]             f_redirect_pc_q;

  logic [31:0] inst, pc, imm_i, imm_s, imm_b, imm_u, imm_j, target;
  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic        empty, full, pop, push, redirect, redirect_n;
  opnd_t       op1, op2;

  // Bypass from the packet currently presented on d_* takes precedence over the RF view.
  function automatic opnd_t resolve(input logic [4:0] rs, input logic [31:0] rf_val,
                                    input logic rf_has_dep, input logic [ROB_IDX_W-1:0] rf_dep,
                                    input logic q_rdy, input logic [31:0] q_val,
                                    input pkt_t cur, input logic [ROB_IDX_W-1:0] tail);
    opnd_t o;
    o = '0;
    if (rs == 5'd0) begin
      o.val = 32'd0;
    end else if (cur.valid && cur.rd == rs) begin
      if (cur.rob_ready) o.val = cur.rob_value;
      else begin
        o.dep = 1'b1;
        o.idx = tail;
      end
    end else if (rf_has_dep && q_rdy) begin
      o.val = q_val;
    end else if (rf_has_dep) begin
      o.dep = 1'b1;
      o.idx = rf_dep;
    end else begin
      o.val = rf_val;
    end
    return o;
  endfunction

  assign empty  = head_q == tail_q;
  assign full   = (head_q[IQ_DEPTH_BIT] != tail_q[IQ_DEPTH_BIT]) &&
                  (head_q[IQ_DEPTH_BIT-1:0] == tail_q[IQ_DEPTH_BIT-1:0]);
  assign inst   = data_mem[head_q[IQ_DEPTH_BIT-1:0]];
  assign pc     = addr_mem[head_q[IQ_DEPTH_BIT-1:0]];
  assign opcode = inst[6:0];
  assign f3     = inst[14:12];
  assign imm_i  = {{20{inst[31]}}, inst[31:20]};
  assign imm_s  = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b  = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u  = {inst[31:12], 12'd0};
  assign imm_j  = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

  assign op1 = resolve(inst[19:15], bus.rf_val1, bus.rf_has_dep1, bus.rf_dep1, bus.rob_q_rdy1,
                       bus.rob_q_val1, pkt_q, bus.rob_tail);
  assign op2 = resolve(inst[24:20], bus.rf_val2, bus.rf_has_dep2, bus.rf_dep2, bus.rob_q_rdy2,
                       bus.rob_q_val2, pkt_q, bus.rob_tail);

  always_comb begin
    pkt_n      = '0;
    pkt_n.valid = 1'b1;
    pkt_n.addr = pc;
    redirect_n = 1'b0;
    target     = 32'd0;
    case (opcode)
      OpLui: begin
        pkt_n.rob_ready = 1'b1;
        pkt_n.rob_value = imm_u;
        pkt_n.rd        = inst[11:7];
      end
      OpAuipc: begin
        pkt_n.rob_ready = 1'b1;
        pkt_n.rob_value = pc + imm_u;
        pkt_n.rd        = inst[11:7];
      end
      OpJal: begin
        pkt_n.rob_ready = 1'b1;
        pkt_n.rob_value = pc + 32'd4;
        pkt_n.rd        = inst[11:7];
        redirect_n      = 1'b1;
        target          = pc + imm_j;
      end
      OpJalr: begin
        pkt_n.rob_ready = 1'b1;
        pkt_n.rob_value = pc + 32'd4;
        pkt_n.rd        = inst[11:7];
        redirect_n      = 1'b1;
        target          = (op1.val + imm_i) & ~32'd1;
      end
      OpBranch: begin
        pkt_n.unit     = 2'd1;
        pkt_n.op       = {1'b1, 1'b0, f3};
        pkt_n.r1       = op1.val;
        pkt_n.r2       = op2.val;
        pkt_n.has_dep1 = op1.dep;
        pkt_n.dep1     = op1.idx;
        pkt_n.has_dep2 = op2.dep;
        pkt_n.dep2     = op2.idx;
        if (PRED_EN && inst[31]) begin
          pkt_n.pred_taken = 1'b1;
          pkt_n.rob_value  = pc + 32'd4;
          redirect_n       = 1'b1;
          target           = pc + imm_b;
        end else begin
          pkt_n.rob_value  = pc + imm_b;
        end
      end
      OpLoad: begin
        pkt_n.unit     = 2'd2;
        pkt_n.op       = {2'b00, f3};
        pkt_n.r1       = op1.val;
        pkt_n.has_dep1 = op1.dep;
        pkt_n.dep1     = op1.idx;
        pkt_n.imm      = imm_i;
        pkt_n.rd       = inst[11:7];
      end
      OpStore: begin
        pkt_n.unit      = 2'd2;
        pkt_n.op        = {2'b10, f3};
        pkt_n.r1        = op1.val;
        pkt_n.r2        = op2.val;
        pkt_n.has_dep1  = op1.dep;
        pkt_n.dep1      = op1.idx;
        pkt_n.has_dep2  = op2.dep;
        pkt_n.dep2      = op2.idx;
        pkt_n.imm       = imm_s;
        pkt_n.rob_ready = 1'b1;
      end
      OpImm: begin
        pkt_n.unit     = 2'd1;
        // SRAI carries its arithmetic bit in f7 just like SRA.
        pkt_n.op       = {1'b0, inst[30] & (f3 == 3'b101), f3};
        pkt_n.r1       = op1.val;
        pkt_n.has_dep1 = op1.dep;
        pkt_n.dep1     = op1.idx;
        pkt_n.r2       = (f3[1:0] == 2'b01) ? {27'd0, inst[24:20]} : imm_i;
        pkt_n.rd       = inst[11:7];
      end
      OpReg: begin
        pkt_n.unit     = 2'd1;
        pkt_n.op       = {1'b0, inst[30], f3};
        pkt_n.r1       = op1.val;
        pkt_n.r2       = op2.val;
        pkt_n.has_dep1 = op1.dep;
        pkt_n.dep1     = op1.idx;
        pkt_n.has_dep2 = op2.dep;
        pkt_n.dep2     = op2.idx;
        pkt_n.rd       = inst[11:7];
      end
      default: pkt_n.rob_ready = 1'b1;
    endcase
  end

  assign pop = !empty && !bus.rob_full &&
               !(pkt_n.unit == 2'd1 && bus.rs_full) &&
               !(pkt_n.unit == 2'd2 && bus.lsb_full) &&
               !(opcode == OpJalr && op1.dep);
  assign redirect = pop && redirect_n;
  assign push     = bus.if_valid && bus.if_ready && !redirect;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      head_q          <= '0;
      tail_q          <= '0;
      pkt_q           <= '0;
      f_redirect_q    <= 1'b0;
      f_redirect_pc_q <= 32'd0;
    end else if (bus.rob_clear) begin
      head_q          <= '0;
      tail_q          <= '0;
      pkt_q           <= '0;
      f_redirect_q    <= 1'b0;
      f_redirect_pc_q <= 32'd0;
    end else if (bus.rdy_in) begin
      if (redirect)  head_q <= tail_q;
      else if (pop)  head_q <= head_q + 1'b1;
      if (push)      tail_q <= tail_q + 1'b1;
      if (pop)       pkt_q <= pkt_n;
      else           pkt_q.valid <= 1'b0;
      f_redirect_q <= redirect;
      if (redirect)  f_redirect_pc_q <= target;
    end
  end

  always_ff @(posedge clk_in) begin
    if (bus.rdy_in && !bus.rob_clear && push) begin
      addr_mem[tail_q[IQ_DEPTH_BIT-1:0]] <= bus.if_addr;
      data_mem[tail_q[IQ_DEPTH_BIT-1:0]] <= bus.if_data;
    end
  end

  assign bus.if_ready      = !full && !f_redirect_q;
  assign bus.f_redirect    = f_redirect_q;
  assign bus.f_redirect_pc = f_redirect_pc_q;
  assign bus.rf_idx1       = inst[19:15];
  assign bus.rf_idx2       = inst[24:20];
  assign bus.rob_q_idx1    = bus.rf_dep1;
  assign bus.rob_q_idx2    = bus.rf_dep2;
  assign bus.d_valid       = pkt_q.valid;
  assign bus.d_unit        = pkt_q.unit;
  assign bus.d_op          = pkt_q.op;
  assign bus.d_r1          = pkt_q.r1;
  assign bus.d_r2          = pkt_q.r2;
  assign bus.d_has_dep1    = pkt_q.has_dep1;
  assign bus.d_has_dep2    = pkt_q.has_dep2;
  assign bus.d_dep1        = pkt_q.dep1;
  assign bus.d_dep2        = pkt_q.dep2;
  assign bus.d_imm         = pkt_q.imm;
  assign bus.d_rd          = pkt_q.rd;
  assign bus.d_rob_ready   = pkt_q.rob_ready;
  assign bus.d_rob_value   = pkt_q.rob_value;
  assign bus.d_pred_taken  = pkt_q.pred_taken;
  assign bus.d_addr        = pkt_q.addr;
endmodule

// File: tb/tb_decode_queue.sv
// Directed bench for decode_queue: fill/stall, rename bypass, prediction, JALR wait,
// flush/reset and freeze behaviour.
module tb_decode_queue;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  logic [31:0] regs [32];
  logic        pend [32];
  logic [3:0]  pdep [32];

  decode_queue_if #(.ROB_IDX_W(4)) bus ();

  decode_queue #(.IQ_DEPTH_BIT(2), .ROB_IDX_W(4), .PRED_EN(1'b1)) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Register file model answering the head's source indices.
  always_comb begin
    bus.rf_val1     = regs[bus.rf_idx1];
    bus.rf_val2     = regs[bus.rf_idx2];
    bus.rf_has_dep1 = pend[bus.rf_idx1];
    bus.rf_has_dep2 = pend[bus.rf_idx2];
    bus.rf_dep1     = pdep[bus.rf_idx1];
    bus.rf_dep2     = pdep[bus.rf_idx2];
  end

  function automatic logic [31:0] enc_addi(input logic [4:0] rd, input logic [4:0] rs1,
                                           input logic [11:0] imm);
    return {imm, rs1, 3'b000, rd, 7'b0010011};
  endfunction

  function automatic logic [31:0] enc_add(input logic [4:0] rd, input logic [4:0] rs1,
                                          input logic [4:0] rs2);
    return {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_beq(input logic [4:0] rs1, input logic [4:0] rs2,
                                          input logic [12:0] imm);
    return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_jalr(input logic [4:0] rd, input logic [4:0] rs1,
                                           input logic [11:0] imm);
    return {imm, rs1, 3'b000, rd, 7'b1100111};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic v, input logic [31:0] a, input logic [31:0] d);
    bus.if_valid = v;
    bus.if_addr  = a;
    bus.if_data  = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 32; i++) begin
      regs[i] = 32'd0;
      pend[i] = 1'b0;
      pdep[i] = 4'd0;
    end
    bus.rdy_in = 1'b1;
    bus.rob_clear = 1'b0;
    fetch(1'b0, 32'd0, 32'd0);
    bus.rob_q_rdy1 = 1'b0;
    bus.rob_q_rdy2 = 1'b0;
    bus.rob_q_val1 = 32'd0;
    bus.rob_q_val2 = 32'd0;
    bus.rob_tail   = 4'd0;
    bus.rob_full   = 1'b0;
    bus.rs_full    = 1'b0;
    bus.lsb_full   = 1'b0;
    step();
    step();
    chk("rst_d_valid", bus.d_valid, 0);
    chk("rst_f_redirect", bus.f_redirect, 0);
    chk("rst_d_addr", bus.d_addr, 0);
    rst = 1'b0;
    chk("rst_if_ready", bus.if_ready, 1);

    // 1: fill while stalled, then drain in PC order
    bus.rob_full = 1'b1;
    bus.rs_full  = 1'b1;
    bus.lsb_full = 1'b1;
    for (int k = 0; k < 4; k++) begin
      fetch(1'b1, 32'(k * 4), enc_addi(5'(k + 1), 5'd0, 12'(k + 1)));
      step();
      chk("fill_if_ready", bus.if_ready, (k == 3) ? 32'd0 : 32'd1);
      chk("fill_no_dispatch", bus.d_valid, 0);
    end
    fetch(1'b0, 32'd0, 32'd0);
    bus.rob_full = 1'b0;
    bus.rs_full  = 1'b0;
    bus.lsb_full = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("drain_valid", bus.d_valid, 1);
      chk("drain_addr", bus.d_addr, 32'(k * 4));
      chk("drain_r2_imm", bus.d_r2, 32'(k + 1));
    end
    chk("drain_rd", bus.d_rd, 4);
    chk("drain_unit", bus.d_unit, 1);
    step();
    chk("drain_done", bus.d_valid, 0);

    // 2: back-to-back dependency renamed to rob_tail of the packet on d_*
    regs[1] = 32'h55;
    fetch(1'b1, 32'h10, enc_addi(5'd1, 5'd0, 12'd5));
    step();
    fetch(1'b1, 32'h14, enc_add(5'd2, 5'd1, 5'd1));
    step();
    fetch(1'b0, 32'd0, 32'd0);
    chk("dep_first_rd", bus.d_rd, 1);
    chk("dep_first_r2", bus.d_r2, 5);
    bus.rob_tail = 4'd7;
    step();
    chk("dep_second_valid", bus.d_valid, 1);
    chk("dep_second_addr", bus.d_addr, 32'h14);
    chk("dep_has_dep1", bus.d_has_dep1, 1);
    chk("dep_has_dep2", bus.d_has_dep2, 1);
    chk("dep_dep1", bus.d_dep1, 7);
    chk("dep_dep2", bus.d_dep2, 7);
    chk("dep_op", bus.d_op, 0);
    step();

    // 3: backward branch predicted taken, younger words discarded
    fetch(1'b1, 32'h100, enc_beq(5'd0, 5'd0, 13'h1FF8));
    step();
    fetch(1'b1, 32'h104, enc_addi(5'd3, 5'd0, 12'd1));
    step();
    fetch(1'b1, 32'h108, enc_addi(5'd4, 5'd0, 12'd2));
    chk("br_valid", bus.d_valid, 1);
    chk("br_redirect", bus.f_redirect, 1);
    chk("br_target", bus.f_redirect_pc, 32'hF8);
    chk("br_pred", bus.d_pred_taken, 1);
    chk("br_rob_value", bus.d_rob_value, 32'h104);
    chk("br_op", bus.d_op, 5'b10000);
    chk("br_if_ready", bus.if_ready, 0);
    step();
    fetch(1'b0, 32'd0, 32'd0);
    chk("br_pulse_end", bus.f_redirect, 0);
    chk("br_flushed", bus.d_valid, 0);
    step();
    chk("br_flushed2", bus.d_valid, 0);

    // 4a: JALR with ready base
    regs[5] = 32'h1001;
    fetch(1'b1, 32'h200, enc_jalr(5'd1, 5'd5, 12'd8));
    step();
    fetch(1'b0, 32'd0, 32'd0);
    step();
    chk("jalr_redirect", bus.f_redirect, 1);
    chk("jalr_target", bus.f_redirect_pc, 32'h1008);
    chk("jalr_link", bus.d_rob_value, 32'h204);
    chk("jalr_rob_ready", bus.d_rob_ready, 1);
    step();
    chk("jalr_pulse_end", bus.f_redirect, 0);

    // 4b: JALR waits for its pending base
    pend[5] = 1'b1;
    pdep[5] = 4'd3;
    fetch(1'b1, 32'h300, enc_jalr(5'd1, 5'd5, 12'd8));
    step();
    fetch(1'b0, 32'd0, 32'd0);
    chk("jalr_q_idx", bus.rob_q_idx1, 3);
    step();
    chk("jalr_wait1", bus.d_valid, 0);
    step();
    chk("jalr_wait2", bus.d_valid, 0);
    bus.rob_q_rdy1 = 1'b1;
    bus.rob_q_val1 = 32'h2000;
    step();
    chk("jalr_go", bus.d_valid, 1);
    chk("jalr_go_target", bus.f_redirect_pc, 32'h2008);
    chk("jalr_go_link", bus.d_rob_value, 32'h304);
    bus.rob_q_rdy1 = 1'b0;
    pend[5] = 1'b0;
    step();

    // 5a: rob_clear beats a simultaneous push and dispatch
    fetch(1'b1, 32'h400, enc_addi(5'd6, 5'd0, 12'd1));
    step();
    fetch(1'b1, 32'h404, enc_addi(5'd7, 5'd0, 12'd2));
    bus.rob_clear = 1'b1;
    step();
    bus.rob_clear = 1'b0;
    fetch(1'b0, 32'd0, 32'd0);
    chk("clr_valid", bus.d_valid, 0);
    chk("clr_if_ready", bus.if_ready, 1);
    step();
    chk("clr_empty", bus.d_valid, 0);

    // 5b: asynchronous reset mid-burst
    fetch(1'b1, 32'h500, enc_addi(5'd6, 5'd0, 12'd1));
    step();
    fetch(1'b1, 32'h504, enc_addi(5'd7, 5'd0, 12'd2));
    step();
    chk("arst_pre_valid", bus.d_valid, 1);
    rst = 1'b1;
    #2;
    chk("arst_valid", bus.d_valid, 0);
    chk("arst_addr", bus.d_addr, 0);
    chk("arst_rd", bus.d_rd, 0);
    rst = 1'b0;
    fetch(1'b0, 32'd0, 32'd0);
    step();
    chk("arst_empty", bus.d_valid, 0);

    // 6: freeze holds d_* and the queue
    fetch(1'b1, 32'h600, enc_addi(5'd3, 5'd0, 12'd7));
    step();
    fetch(1'b1, 32'h604, enc_addi(5'd4, 5'd0, 12'd9));
    step();
    fetch(1'b0, 32'd0, 32'd0);
    bus.rdy_in = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("frz_valid", bus.d_valid, 1);
      chk("frz_addr", bus.d_addr, 32'h600);
    end
    bus.rdy_in = 1'b1;
    step();
    chk("frz_next_valid", bus.d_valid, 1);
    chk("frz_next_addr", bus.d_addr, 32'h604);
    step();
    chk("frz_drained", bus.d_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
